cam_reg_seq: RTL

- Parametrised camera-sensor register-initialisation sequencer.
- Walks a configuration table held in an external synchronous ROM and issues one register write per entry to the SCCB/I2C master over a valid/ack handshake.
- Supports configurable address/data widths and table depth, millisecond delay pseudo-entries, a power-up wait, NACK retry with error reporting, and restart on demand.
- Sits between the ROM and the SCCB master in the camera front end.

---
 rtl/cam_reg_if.sv | 25 ++
 rtl/cam_reg_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/cam_reg_if.sv
// Table-ROM read port and register-write handshake between the init sequencer
// (master) and the ROM / SCCB master side (slave).
interface cam_reg_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int IDX_W  = 8
);
   logic [IDX_W-1:0]         tbl_idx;
   logic [ADDR_W+DATA_W-1:0] tbl_data;
   logic                     wr_vld;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     wr_ack;
   logic                     wr_nack;

   modport master (
      output tbl_idx, wr_vld, wr_addr, wr_data,
      input  tbl_data, wr_ack, wr_nack
   );

   modport slave (
      input  tbl_idx, wr_vld, wr_addr, wr_data,
      output tbl_data, wr_ack, wr_nack
   );
endinterface

// File: rtl/cam_reg_seq.sv
// Camera-sensor register-initialisation sequencer: walks a {addr,value} table in a
// synchronous ROM and issues one register write per entry, with delays and NACK retry.
module cam_reg_seq #(
   parameter int                ADDR_W     = 8,
   parameter int                DATA_W     = 8,
   parameter int                NUM_REGS   = 165,
   parameter int                IDX_W      = 8,
   parameter int                CLK_KHZ    = 25000,
   parameter int                STARTUP_MS = 0,
   parameter logic [ADDR_W-1:0] DELAY_KEY  = '1,
   parameter int                MAX_RETRY  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   cam_reg_if.master        bus,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [IDX_W-1:0] err_idx
);
   localparam int SU_W    = $clog2(STARTUP_MS + 1);
   localparam int MS_W    = (SU_W > DATA_W) ? SU_W : DATA_W;
   localparam int PRE_W   = (CLK_KHZ > 1) ? $clog2(CLK_KHZ) : 1;
   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_WAIT_START, S_FETCH, S_LATCH, S_SEND,
      S_WAIT_ACK, S_DELAY, S_DONE, S_ERROR
   } state_t;

   state_t             state, state_d;
   logic [IDX_W-1:0]   idx;
   logic [RETRY_W-1:0] retry_cnt;
   logic [MS_W-1:0]    ms_left;
   logic [PRE_W-1:0]   pre_cnt;

   logic              launch, advance, do_retry, do_fail;
   logic              pre_wrap, timer_end, last_entry, is_delay;
   logic [ADDR_W-1:0] ent_addr;
   logic [DATA_W-1:0] ent_val;

   assign ent_addr   = bus.tbl_data[ADDR_W+DATA_W-1 -: ADDR_W];
   assign ent_val    = bus.tbl_data[DATA_W-1:0];
   assign is_delay   = (ent_addr == DELAY_KEY);
   assign last_entry = (idx == IDX_W'(NUM_REGS - 1));
   assign pre_wrap   = (pre_cnt == PRE_W'(CLK_KHZ - 1));
   // A zero-length wait ends on its first cycle; otherwise on the last prescaler tick of the last ms.
   assign timer_end  = (ms_left == '0) || (pre_wrap && (ms_left == MS_W'(1)));
   assign bus.tbl_idx = idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d  = state;
      launch   = 1'b0;
      advance  = 1'b0;
      do_retry = 1'b0;
      do_fail  = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               launch  = 1'b1;
               state_d = (STARTUP_MS > 0) ? S_WAIT_START : S_FETCH;
            end
         end
         S_WAIT_START: if (timer_end) state_d = S_FETCH;
         S_FETCH:      state_d = S_LATCH;
         S_LATCH:      state_d = is_delay ? S_DELAY : S_SEND;
         S_SEND:       state_d = S_WAIT_ACK;
         S_WAIT_ACK: begin
            // nack takes priority over a coincident ack
            if (bus.wr_nack) begin
               if (int'(retry_cnt) < MAX_RETRY) begin
                  do_retry = 1'b1;
                  state_d  = S_SEND;
               end else begin
                  do_fail = 1'b1;
                  state_d = S_ERROR;
               end
            end else if (bus.wr_ack) begin
               advance = 1'b1;
            end
         end
         S_DELAY: if (timer_end) advance = 1'b1;
         default: state_d = S_IDLE;
      endcase
      if (advance) state_d = last_entry ? S_DONE : S_FETCH;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         err_idx     <= '0;
         idx         <= '0;
         retry_cnt   <= '0;
         ms_left     <= '0;
         pre_cnt     <= '0;
         bus.wr_vld  <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
      end else begin
         if (launch) begin
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            err_idx   <= '0;
            idx       <= '0;
            retry_cnt <= '0;
            ms_left   <= MS_W'(STARTUP_MS);
            pre_cnt   <= '0;
         end
         if (state == S_WAIT_START || state == S_DELAY) begin
            if (pre_wrap) begin
               pre_cnt <= '0;
               if (ms_left != '0) ms_left <= ms_left - MS_W'(1);
            end else begin
               pre_cnt <= pre_cnt + PRE_W'(1);
            end
         end
         if (state == S_LATCH) begin
            bus.wr_addr <= ent_addr;
            bus.wr_data <= ent_val;
            ms_left     <= MS_W'(ent_val);
            pre_cnt     <= '0;
         end
         if (state == S_SEND) bus.wr_vld <= 1'b1;
         if (state == S_WAIT_ACK && (do_retry || do_fail || advance)) bus.wr_vld <= 1'b0;
         if (do_retry) retry_cnt <= retry_cnt + RETRY_W'(1);
         if (do_fail) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            err_idx <= idx;
         end
         if (advance) begin
            if (last_entry) begin
               done <= 1'b1;
               busy <= 1'b0;
            end else begin
               idx       <= idx + IDX_W'(1);
               retry_cnt <= '0;
            end
         end
      end
   end
endmodule
